// File: rtl/ks_pipelined_subtractor_if.sv
// Operand/result handshake bundle for ks_pipelined_subtractor.
// The master drives operands and out_ready; the slave (the subtractor) returns the result.
interface ks_pipelined_subtractor_if #(
   parameter int N = 64
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] diff;
   logic         borrow;
   logic         overflow;
   logic         zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow, overflow, zero
   );
endinterface

// File: rtl/ks_pipelined_subtractor.sv
// Pipelined Kogge-Stone subtractor: diff = a + ~b + 1, one register per prefix level.
// A single global advance freezes every stage together, so bubbles are never compressed.
module ks_pipelined_subtractor #(
   parameter int N = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ks_pipelined_subtractor_if.slave bus
);
   localparam int L = $clog2(N);

   logic adv;

   logic [N-1:0] g_in;
   logic [N-1:0] p_in;

   // g_p[k]/p_p[k] hold the prefix terms after level k (k = 0 is the preprocess stage)
   logic [L:0][N-1:0]   g_d,  g_p;
   logic [L-1:0][N-1:0] p_d,  p_p;
   logic [L:0][N-1:0]   psum_d, psum_p;
   logic [L:0]          a_msb_d, a_msb_p;
   logic [L:0]          b_msb_d, b_msb_p;
   logic [L:0]          vld_d, vld_p;

   logic [N-1:0] carry;
   logic [N-1:0] diff_d;
   logic         borrow_d;
   logic         overflow_d;
   logic         zero_d;

   logic [N-1:0] diff_po;
   logic         out_valid_po;
   logic         borrow_po;
   logic         overflow_po;
   logic         zero_po;

   assign adv          = ~out_valid_po | bus.out_ready;
   assign bus.in_ready = adv;

   // S0: generate/propagate for a + ~b, carry-in of 1 folded into bit 0
   assign p_in = ~(bus.a ^ bus.b);
   assign g_in = (bus.a & ~bus.b) | {{(N-1){1'b0}}, p_in[0]};

   assign g_d[0]   = g_in;
   assign p_d[0]   = p_in;
   assign psum_d   = {psum_p[L-1:0], p_in};
   assign a_msb_d  = {a_msb_p[L-1:0], bus.a[N-1]};
   assign b_msb_d  = {b_msb_p[L-1:0], bus.b[N-1]};
   assign vld_d    = {vld_p[L-1:0], bus.in_valid};

   // S1..SL: black cell at every position; bits below the span see a zero shifted G
   for (genvar k = 1; k <= L; k++) begin : g_lvl
      localparam int D = 1 << (k - 1);
      assign g_d[k] = g_p[k-1] | (p_p[k-1] & {g_p[k-1][N-1-D:0], {D{1'b0}}});
      if (k < L) begin : g_prop
         assign p_d[k] = {p_p[k-1][N-1:D] & p_p[k-1][N-1-D:0], p_p[k-1][D-1:0]};
      end
   end

   // SO: carry into bit i is the group generate of bits [i-1:0]
   assign carry      = {g_p[L][N-2:0], 1'b1};
   assign diff_d     = psum_p[L] ^ carry;
   assign borrow_d   = ~g_p[L][N-1];
   assign overflow_d = (a_msb_p[L] ^ b_msb_p[L]) & (diff_d[N-1] ^ a_msb_p[L]);
   assign zero_d     = ~|diff_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_p          <= '0;
         p_p          <= '0;
         psum_p       <= '0;
         a_msb_p      <= '0;
         b_msb_p      <= '0;
         vld_p        <= '0;
         diff_po      <= '0;
         out_valid_po <= 1'b0;
         borrow_po    <= 1'b0;
         overflow_po  <= 1'b0;
         zero_po      <= 1'b0;
      end else if (adv) begin
         g_p          <= g_d;
         p_p          <= p_d;
         psum_p       <= psum_d;
         a_msb_p      <= a_msb_d;
         b_msb_p      <= b_msb_d;
         vld_p        <= vld_d;
         diff_po      <= diff_d;
         out_valid_po <= vld_p[L];
         borrow_po    <= borrow_d;
         overflow_po  <= overflow_d;
         zero_po      <= zero_d;
      end
   end

   assign bus.out_valid = out_valid_po;
   assign bus.diff      = diff_po;
   assign bus.borrow    = borrow_po;
   assign bus.overflow  = overflow_po;
   assign bus.zero      = zero_po;
endmodule

// File: doc/ks_pipelined_subtractor.md
Name: ks_pipelined_subtractor

Overview:
- Pipelined Kogge-Stone parallel-prefix subtractor. Computes diff = a - b as a + ~b + 1, with carry-in folded into bit 0.
- One register stage per prefix level, plus a valid/ready handshake on the input and output sides.
- Sits beside the combinational Kogge-Stone adder in the arithmetic library. It is the subtract/compare direction for datapaths that need throughput of one operation per clock at high frequency.

Parameters:
- N, 64, operand width. Must be a power of 2 and at least 4. L = $clog2(N) prefix levels.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  N  minuend, unsigned or two's complement
- b  input  N  subtrahend
- out_valid  output  1  result fields are valid
- out_ready  input  1  downstream consumes the result this cycle
- diff  output  N  a - b, modulo 2^N
- borrow  output  1  1 when a < b as unsigned values (equals ~carry-out)
- overflow  output  1  signed overflow
- zero  output  1  1 when diff == 0

Behaviour:
- Reset (asynchronous, active-low): all stage valid bits = 0 and all pipeline data registers = 0. Outputs are therefore out_valid=0, diff=0, borrow=0, overflow=0, zero=0. in_ready=1 whenever rst_n=1.
- Global advance signal: adv = ~out_valid | out_ready. in_ready = adv. Every stage register loads only when adv=1, otherwise it holds. Valid bits shift one stage per adv.
- Bubbles are not compressed; a bubble occupies its stage like a token.
- S0 (preprocess, loads when adv=1):
  - g[i] = a[i] & ~b[i]; p[i] = ~(a[i] ^ b[i]).
  - Bit 0 carry-in fold: g[0] = g[0] | p[0].
  - Also registers raw p as psum, plus a[N-1] and b[N-1].
  - v0 = in_valid.
- S1..SL (prefix levels): level k (distance d = 2^(k-1)):
  - For i >= d: G[i] = G[i] | (P[i] & G[i-d]); P[i] = P[i] & P[i-d].
  - For i < d: G and P pass through unchanged.
  - psum and the sign bits pass through unchanged.
  - Every level is a black cell.
- SO (output register, loads when adv=1):
  - c[0] = 1; c[i] = G[i-1] for i >= 1.
  - diff = psum ^ c.
  - borrow = ~G[N-1].
  - overflow = (a_msb != b_msb) & (diff[N-1] != a_msb).
  - zero = (diff == 0).
  - out_valid = vL.
- Latency: an operand pair accepted at rising edge k is presented with out_valid=1 after edge k+L+1 (7 cycles for N=64, 4 cycles for N=8), provided no stall occurs.
- Throughput: one operation per cycle while out_ready=1.
- Stall (out_valid=1 and out_ready=0):
  - The whole pipeline freezes and in_ready=0.
  - diff, borrow, overflow and zero stay bit-stable until the cycle out_ready=1.
- Simultaneous out_valid & out_ready & in_valid: the result is consumed and a new operand pair is accepted in the same edge. No loss and no duplication.
- Output fields are don't-care while out_valid=0, except after reset, when they are 0.
- Reset mid-operation: all in-flight operations are discarded, with no output. The first accept after reset behaves as from idle.
- No combinational path from in_valid, a or b to any output. in_ready depends combinationally only on out_ready and the out_valid register.

Test Plan:
- N=8, a=0x05, b=0x03, out_ready=1 -> after 4 cycles: diff=0x02, borrow=0, overflow=0, zero=0.
- N=8, a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0. Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
- N=64, a=b=0xDEADBEEF_CAFEF00D -> diff=0, zero=1, borrow=0. Also a=0, b=1 -> diff=all ones, borrow=1. Latency is exactly 7 cycles.
- Backpressure:
  - Stream 20 back-to-back random pairs; hold out_ready=0 for 3 cycles mid-stream.
  - Required: outputs stay stable and in_ready=0 during the hold.
  - Results arrive in order and match a reference model; no drops or duplicates.
  - Throughput is 1 per cycle once out_ready returns to 1.
- Reset mid-operation:
  - Accept 3 pairs, then pulse rst_n low for 1 cycle, asynchronously, between clock edges.
  - Required: out_valid=0 immediately and no stale result ever appears.
  - The next pair is accepted and produces a correct result after 4 cycles (N=8).
- Exhaustive N=8: all 65536 pairs streamed with random in_valid and out_ready gaps -> diff, borrow, overflow and zero all match the model.
